// File: rtl/config_sram_burst_loader.sv
// config_sram_burst_loader: serial config-chain loader that bursts words into banked config SRAMs
// Ports:
//   cclk, rst (async, active-high)  config clock and reset
//   start                           abort any burst and arm for a new header
//   shift_enable, shift_in          qualified serial input bit
//   shift_out                       daisy-chain output, MSB of the shift register
//   write_enable[BANKS]             one-hot per-bank write strobe, one cycle per word
//   write_address, write_data       address/data of the current write, held between writes
//   busy, done, error               in header/data phase, burst complete, bad bank in header
module config_sram_burst_loader #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8,
   parameter int CNT_BITS  = 8,
   parameter int BANKS     = 2
) (
   input  logic                 cclk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 shift_enable,
   input  logic                 shift_in,
   output logic                 shift_out,
   output logic [BANKS-1:0]     write_enable,
   output logic [ADDR_BITS-1:0] write_address,
   output logic [DATA_BITS-1:0] write_data,
   output logic                 busy,
   output logic                 done,
   output logic                 error
);
   localparam int BANK_BITS = BANKS > 1 ? $clog2(BANKS) : 1;
   localparam int HDR_BITS  = BANK_BITS + ADDR_BITS + CNT_BITS;
   localparam int SR_BITS   = HDR_BITS > DATA_BITS ? HDR_BITS : DATA_BITS;
   localparam int CW        = $clog2(SR_BITS + 1);
   localparam logic [CW-1:0] HDR_LAST  = CW'(HDR_BITS - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
   localparam logic [BANK_BITS:0] BANK_LIM = (BANK_BITS + 1)'(BANKS);
   typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;
   state_t state, state_n;
   logic [SR_BITS-1:0]   sr, sr_n;
   logic [CW-1:0]        bit_cnt;
   logic [BANK_BITS-1:0] bank, hdr_bank;
   logic [ADDR_BITS-1:0] addr;
   logic [CNT_BITS-1:0]  remaining;
   logic                 hdr_last, word_last;
   assign shift_out = sr[SR_BITS-1];
   assign busy      = state == HDR || state == DATA;
   // header fields and data word are taken from the post-shift value so the
   // completing bit is included in the same cycle
   always_comb begin
      sr_n      = {sr[SR_BITS-2:0], shift_in};
      hdr_bank  = sr_n[HDR_BITS-1 -: BANK_BITS];
      hdr_last  = state == HDR && shift_enable && bit_cnt == HDR_LAST;
      word_last = state == DATA && shift_enable && bit_cnt == DATA_LAST;
      state_n   = start ? HDR : hdr_last ? DATA : (word_last && remaining == '0) ? DONE : state;
   end
   always_ff @(posedge cclk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end
   always_ff @(posedge cclk or posedge rst) begin
      if (rst) begin
         sr            <= '0;
         bit_cnt       <= '0;
         bank          <= '0;
         addr          <= '0;
         remaining     <= '0;
         write_enable  <= '0;
         write_address <= '0;
         write_data    <= '0;
         done          <= 1'b0;
         error         <= 1'b0;
      end else begin
         if (shift_enable) sr <= sr_n;
         write_enable <= '0;
         // start wins over a word completing in the same cycle
         if (start) begin
            bit_cnt <= '0;
            done    <= 1'b0;
            error   <= 1'b0;
         end else if (hdr_last) begin
            bit_cnt   <= '0;
            bank      <= hdr_bank;
            addr      <= sr_n[ADDR_BITS+CNT_BITS-1 -: ADDR_BITS];
            remaining <= sr_n[CNT_BITS-1:0];
            error     <= {1'b0, hdr_bank} >= BANK_LIM;
         end else if (word_last) begin
            bit_cnt       <= '0;
            write_data    <= sr_n[DATA_BITS-1:0];
            write_address <= addr;
            addr          <= addr + 1'b1;
            if (!error) write_enable <= BANKS'(1) << bank;
            if (remaining == '0) done <= 1'b1;
            else remaining <= remaining - 1'b1;
         end else if (busy && shift_enable) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_config_sram_burst_loader.sv
// tb_config_sram_burst_loader: directed bench for the burst loader (BANKS=2 and BANKS=3 instances)
module tb_config_sram_burst_loader;
   logic cclk = 1'b0, rst = 1'b1, start = 1'b0, shift_enable = 1'b0, shift_in = 1'b0;
   logic       shift_out, busy, done, error;
   logic [1:0] write_enable;
   logic [7:0] write_address, write_data;
   logic       shift_out3, busy3, done3, error3;
   logic [2:0] write_enable3;
   logic [7:0] write_address3, write_data3;
   int n_assert = 0, n_fail = 0;
   logic [17:0] wq[$];
   int w3 = 0;
   logic [16:0] model_sr = '0;
   bit gaps = 0, chk_so = 0;
   int base, base3;

   config_sram_burst_loader dut (
      .cclk(cclk), .rst(rst), .start(start), .shift_enable(shift_enable), .shift_in(shift_in),
      .shift_out(shift_out), .write_enable(write_enable), .write_address(write_address),
      .write_data(write_data), .busy(busy), .done(done), .error(error));

   config_sram_burst_loader #(.BANKS(3)) dut3 (
      .cclk(cclk), .rst(rst), .start(start), .shift_enable(shift_enable), .shift_in(shift_in),
      .shift_out(shift_out3), .write_enable(write_enable3), .write_address(write_address3),
      .write_data(write_data3), .busy(busy3), .done(done3), .error(error3));

   always #5 cclk = ~cclk;

   always @(negedge cclk) begin
      if (write_enable != '0) wq.push_back({write_enable, write_address, write_data});
      if (write_enable3 != '0) w3++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wr(input int i, input logic [1:0] we, input logic [7:0] a, input logic [7:0] d);
      chk($sformatf("write%0d", i), {14'd0, wq[i]}, {14'd0, we, a, d});
   endtask

   task automatic clk_bit(input logic b, input logic st = 1'b0);
      if (gaps) repeat ($urandom_range(0, 2)) begin
         shift_enable = 1'b0;
         shift_in = 1'($urandom);
         @(posedge cclk); #1;
      end
      shift_enable = 1'b1;
      shift_in = b;
      start = st;
      @(posedge cclk); #1;
      shift_enable = 1'b0;
      start = 1'b0;
      model_sr = {model_sr[15:0], b};
      if (chk_so) chk("shift_out", {31'd0, shift_out}, {31'd0, model_sr[16]});
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) clk_bit(v[i]);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      shift_enable = 1'b0;
      @(posedge cclk); #1;
      start = 1'b0;
   endtask

   task automatic scenario2();
      base = wq.size();
      pulse_start();
      send_bits({15'd0, 1'b1, 8'h10, 8'h02}, 17);
      send_bits(32'hA5, 8);
      send_bits(32'h3C, 8);
      send_bits(32'hFF, 8);
      chk("s2_we_last", {30'd0, write_enable}, 32'h2);
      chk("s2_done", {31'd0, done}, 32'h1);
      chk("s2_busy", {31'd0, busy}, 32'h0);
      @(posedge cclk); #1;
      chk("s2_we_clear", {30'd0, write_enable}, 32'h0);
      chk("s2_nwr", wq.size() - base, 3);
      chk_wr(base, 2'b10, 8'h10, 8'hA5);
      chk_wr(base + 1, 2'b10, 8'h11, 8'h3C);
      chk_wr(base + 2, 2'b10, 8'h12, 8'hFF);
   endtask

   initial begin
      #1;
      chk("rst_we", {30'd0, write_enable}, 0);
      chk("rst_busy_done_err_so", {28'd0, busy, done, error, shift_out}, 0);
      chk("rst_addr_data", {16'd0, write_address, write_data}, 0);
      @(posedge cclk); #1;
      rst = 1'b0;

      // async reset in the middle of a data word
      pulse_start();
      send_bits({15'd0, 1'b1, 8'h10, 8'h02}, 17);
      send_bits(32'hA5, 8);
      send_bits(32'h5, 3);
      chk("t1_busy_pre", {31'd0, busy}, 1);
      chk("t1_data_pre", {24'd0, write_data}, 32'hA5);
      #2 rst = 1'b1;
      model_sr = '0;
      #1;
      chk("t1_addr_data", {16'd0, write_address, write_data}, 0);
      chk("t1_flags", {28'd0, busy, done, error, shift_out}, 0);
      chk("t1_we", {30'd0, write_enable}, 0);
      @(posedge cclk); #1;
      rst = 1'b0;
      base = wq.size();
      send_bits(32'h3FF, 10);
      chk("t1_idle_busy", {31'd0, busy}, 0);
      chk("t1_idle_nwr", wq.size() - base, 0);

      // basic three-word burst
      scenario2();

      // address wrap, bank 0
      base = wq.size();
      pulse_start();
      chk("t3_done_cleared", {31'd0, done}, 0);
      send_bits({15'd0, 1'b0, 8'hFE, 8'h03}, 17);
      send_bits(32'h11, 8);
      send_bits(32'h22, 8);
      send_bits(32'h33, 8);
      send_bits(32'h44, 8);
      send_bits(32'hC7, 8);
      chk("t3_nwr", wq.size() - base, 4);
      chk_wr(base, 2'b01, 8'hFE, 8'h11);
      chk_wr(base + 1, 2'b01, 8'hFF, 8'h22);
      chk_wr(base + 2, 2'b01, 8'h00, 8'h33);
      chk_wr(base + 3, 2'b01, 8'h01, 8'h44);
      chk("t3_done", {31'd0, done}, 1);

      // invalid bank on the 3-bank instance
      base3 = w3;
      pulse_start();
      send_bits({14'd0, 2'b11, 8'h20, 8'h01}, 18);
      chk("t4_error", {31'd0, error3}, 1);
      chk("t4_busy", {31'd0, busy3}, 1);
      send_bits(32'h5A, 8);
      send_bits(32'hA5, 8);
      chk("t4_done", {31'd0, done3}, 1);
      chk("t4_busy_end", {31'd0, busy3}, 0);
      chk("t4_error_sticky", {31'd0, error3}, 1);
      @(posedge cclk); #1;
      chk("t4_nwr", w3 - base3, 0);

      // abort mid-word, then restart
      base = wq.size();
      pulse_start();
      send_bits({15'd0, 1'b1, 8'h40, 8'h02}, 17);
      send_bits(32'h5A, 8);
      send_bits(32'hA, 4);
      pulse_start();
      chk("t5_done_err", {30'd0, done, error}, 0);
      chk("t5_busy", {31'd0, busy}, 1);
      send_bits({15'd0, 1'b0, 8'h80, 8'h00}, 17);
      send_bits(32'hC3, 8);
      chk("t5_done", {31'd0, done}, 1);
      @(posedge cclk); #1;
      chk("t5_nwr", wq.size() - base, 2);
      chk_wr(base, 2'b10, 8'h40, 8'h5A);
      chk_wr(base + 1, 2'b01, 8'h80, 8'hC3);

      // start coinciding with a word's last bit suppresses that write
      base = wq.size();
      pulse_start();
      send_bits({15'd0, 1'b1, 8'h55, 8'h00}, 17);
      send_bits(32'h7F, 7);
      clk_bit(1'b1, 1'b1);
      chk("t5b_we", {30'd0, write_enable}, 0);
      chk("t5b_done", {31'd0, done}, 0);
      send_bits({15'd0, 1'b1, 8'h66, 8'h00}, 17);
      send_bits(32'h99, 8);
      @(posedge cclk); #1;
      chk("t5b_nwr", wq.size() - base, 1);
      chk_wr(base, 2'b10, 8'h66, 8'h99);

      // scenario 2 again with random qualifier gaps and shift_out tracking
      gaps = 1;
      chk_so = 1;
      scenario2();
      gaps = 0;
      chk_so = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
